lvds_tx_frame: RTL and testbench



---
 rtl/lvds_tx_pkg.sv | 15 +
 rtl/lvds_tx_frame_if.sv | 11 +
 rtl/lvds_tx_serdes.sv | 47 ++++
 rtl/lvds_tx_frame.sv | 189 ++++++++++++++++++
 tb/tb_lvds_tx_frame.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the framed two-lane LVDS transmitter.
package lvds_tx_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap
   } tx_state_e;

   localparam int unsigned LANES          = 2;
   localparam int unsigned SLOTS_PER_BYTE = 4;

   localparam logic [7:0] DEFAULT_FILL_BYTE = 8'h00;

endpackage

// File: rtl/lvds_tx_frame_if.sv
// Byte stream feeding the LVDS transmitter (valid/ready handshake).
interface lvds_tx_frame_if;

   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/lvds_tx_serdes.sv
// Byte serialiser: two nibble shifters emit one bit per lane per clock, LSB first.
module lvds_tx_serdes
   import lvds_tx_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [7:0] data_i,
   input  logic       run_i,
   output logic       lane0_o,
   output logic       lane1_o,
   output logic       byte_end_o
);

   localparam int unsigned SlotW    = $clog2(SLOTS_PER_BYTE);
   localparam int unsigned Lane1Lsb = SLOTS_PER_BYTE * (LANES - 1);

   logic [7:0]       shift_q, shift_d;
   logic [SlotW-1:0] slot_q, slot_d;

   // Lanes read straight from the shifter LSBs, so they are register outputs.
   always_comb begin
      shift_d = '0;
      slot_d  = '0;
      if (load_i) begin
         shift_d = data_i;
      end else if (run_i) begin
         shift_d = (shift_q >> 1) & 8'h77;
         slot_d  = slot_q + SlotW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '0;
         slot_q  <= '0;
      end else begin
         shift_q <= shift_d;
         slot_q  <= slot_d;
      end
   end

   assign lane0_o    = shift_q[0];
   assign lane1_o    = shift_q[Lane1Lsb];
   assign byte_end_o = (slot_q == SlotW'(SLOTS_PER_BYTE - 1));

endmodule

// File: rtl/lvds_tx_frame.sv
// Framed 2-lane LVDS transmitter with flag bracketing and underrun fill.
// Define LVDS_TX_SUM_EN to append a 16-bit byte-sum trailer (low byte first).
module lvds_tx_frame
   import lvds_tx_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 896,
   parameter int unsigned MIN_GAP   = 20,
   parameter logic [7:0]  FILL_BYTE = DEFAULT_FILL_BYTE
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   lvds_tx_frame_if.slave strm,
   output logic           lvds_data0,
   output logic           lvds_data1,
   output logic           lvds_flag,
   output logic           busy,
   output logic           frame_done,
   output logic           underrun
);

`ifdef LVDS_TX_SUM_EN
   localparam int unsigned TrailerBytes = 2;
`else
   localparam int unsigned TrailerBytes = 0;
`endif
   localparam int unsigned TotalBytes = FRAME_LEN + TrailerBytes;
   localparam int unsigned CntW       = $clog2(FRAME_LEN + 3);
   localparam int unsigned GapW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   tx_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic [7:0]      hold_q, hold_d;
   logic            hold_vld_q, hold_vld_d;
   logic            pending_q, pending_d;
   logic            flag_q, flag_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            underrun_q, underrun_d;

   logic       byte_end, ser_load, ser_run, consume;
   logic       frame_start, last_byte, data_slot, load_now;
   logic [7:0] ser_data, trailer_byte;

   assign frame_start = (state_q == StIdle) && (pending_q || start) && hold_vld_q;
   assign last_byte   = (cnt_q == CntW'(TotalBytes));
   assign data_slot   = (cnt_q < CntW'(FRAME_LEN));

   // Only registered state feeds s_ready, so it never depends on start combinationally.
   assign load_now = ((state_q == StIdle) && pending_q) ||
                     ((state_q == StSend) && byte_end && data_slot);
   assign strm.s_ready = !hold_vld_q || load_now;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      pending_d  = pending_q | start;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      underrun_d = underrun_q;
      done_d     = 1'b0;
      ser_load   = 1'b0;
      ser_run    = 1'b0;
      ser_data   = hold_q;
      consume    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (frame_start) begin
               state_d    = StSend;
               pending_d  = 1'b0;
               ser_load   = 1'b1;
               consume    = 1'b1;
               cnt_d      = CntW'(1);
               underrun_d = 1'b0;
            end
         end
         StSend: begin
            if (!byte_end) begin
               ser_run = 1'b1;
            end else if (last_byte) begin
               state_d = StGap;
               gap_d   = '0;
               done_d  = 1'b1;
            end else begin
               ser_load = 1'b1;
               cnt_d    = cnt_q + CntW'(1);
               if (!data_slot) begin
                  ser_data = trailer_byte;
               end else if (hold_vld_q) begin
                  consume = 1'b1;
               end else begin
                  ser_data   = FILL_BYTE;
                  underrun_d = 1'b1;
               end
            end
         end
         StGap: begin
            if (gap_q == GapW'(MIN_GAP - 1)) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (consume) begin
         hold_vld_d = 1'b0;
      end
      if (strm.s_valid && strm.s_ready) begin
         hold_d     = strm.s_data;
         hold_vld_d = 1'b1;
      end

      flag_d = (state_d == StSend);
      busy_d = (state_d != StIdle) || pending_d;
   end

`ifdef LVDS_TX_SUM_EN
   logic [15:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (frame_start) begin
         sum_d = {8'h00, ser_data};
      end else if (ser_load && data_slot) begin
         sum_d = sum_q + {8'h00, ser_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign trailer_byte = (cnt_q == CntW'(FRAME_LEN)) ? sum_q[7:0] : sum_q[15:8];
`else
   assign trailer_byte = FILL_BYTE;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         gap_q      <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         pending_q  <= 1'b0;
         flag_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         pending_q  <= pending_d;
         flag_q     <= flag_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   lvds_tx_serdes u_serdes (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (ser_load),
      .data_i     (ser_data),
      .run_i      (ser_run),
      .lane0_o    (lvds_data0),
      .lane1_o    (lvds_data1),
      .byte_end_o (byte_end)
   );

   assign lvds_flag  = flag_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_lvds_tx_frame.sv
// Directed bench for lvds_tx_frame: feeds a byte stream and reassembles the lanes
// against a queue of expected bytes.
module tb_lvds_tx_frame;

   localparam int unsigned FL   = 896;
   localparam int unsigned MG   = 20;
   localparam logic [7:0]  FILL = 8'h00;
`ifdef LVDS_TX_SUM_EN
   localparam int unsigned TRAIL = 2;
`else
   localparam int unsigned TRAIL = 0;
`endif
   localparam int unsigned FLAG_CYC = 4 * (FL + TRAIL);

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;
   logic lvds_data0, lvds_data1, lvds_flag, busy, frame_done, underrun;

   lvds_tx_frame_if strm ();

   lvds_tx_frame #(
      .FRAME_LEN (FL),
      .MIN_GAP   (MG),
      .FILL_BYTE (FILL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .strm       (strm),
      .lvds_data0 (lvds_data0),
      .lvds_data1 (lvds_data1),
      .lvds_flag  (lvds_flag),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] feed[$];
   logic [7:0] exp_q[$];

   int         ncyc      = 0;
   int         run_len   = 0;
   int         last_len  = 0;
   int         fall_ncyc = 0;
   int         rise_ncyc = 0;
   int         last_gap  = 0;
   int         rises     = 0;
   int         done_cnt  = 0;
   int         fbytes    = 0;
   logic [1:0] slot      = 2'd0;
   logic       flag_prev = 1'b0;
   logic [3:0] l0, l1, first0, first1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_start(output int at);
      @(negedge clk);
      #1;
      start = 1'b1;
      at    = ncyc;
      @(negedge clk);
      #1;
      start = 1'b0;
   endtask

   // Queue n_data stream bytes plus the bytes the frame is expected to carry.
   task automatic queue_frame(input int n_data, input int n_fill, input int seed);
      logic [7:0] b;
      for (int i = 0; i < n_data; i++) begin
         b = 8'(((i + seed) % 128) + 1);
         feed.push_back(b);
         exp_q.push_back(b);
      end
      for (int i = 0; i < n_fill; i++) exp_q.push_back(FILL);
`ifdef LVDS_TX_SUM_EN
      begin
         logic [15:0] s;
         s = '0;
         for (int i = exp_q.size() - (n_data + n_fill); i < exp_q.size(); i++)
            s = s + 16'(exp_q[i]);
         exp_q.push_back(s[7:0]);
         exp_q.push_back(s[15:8]);
      end
`endif
   endtask

   task automatic wait_done(input string tag, input int target, input int bound);
      int n;
      n = 0;
      while (done_cnt < target && n < bound) begin
         tick(1);
         n++;
      end
      check(tag, done_cnt, target);
   endtask

   // Stream source: offers the head of feed, pops it when the handshake will fire.
   initial begin
      strm.s_valid = 1'b0;
      strm.s_data  = 8'h00;
      forever begin
         @(negedge clk);
         strm.s_valid = (feed.size() != 0);
         strm.s_data  = (feed.size() != 0) ? feed[0] : 8'h00;
         #4;
         if (strm.s_valid && strm.s_ready && feed.size() != 0) void'(feed.pop_front());
      end
   end

   // Lane monitor: reassembles bytes while the flag is high and times flag edges.
   initial begin : monitor
      logic [8:0] want;
      forever begin
         @(negedge clk);
         ncyc++;
         if (lvds_flag === 1'b1) begin
            if (flag_prev !== 1'b1) begin
               rises++;
               last_gap  = ncyc - fall_ncyc;
               rise_ncyc = ncyc;
               run_len   = 0;
               slot      = 2'd0;
               fbytes    = 0;
            end
            run_len++;
            l0[slot] = lvds_data0;
            l1[slot] = lvds_data1;
            if (slot == 2'd3) begin
               if (fbytes == 0) begin
                  first0 = l0;
                  first1 = l1;
               end
               want = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
               check("byte", {24'h0, l1, l0}, {23'h0, want});
               fbytes++;
            end
            slot = slot + 2'd1;
         end else if (flag_prev === 1'b1) begin
            fall_ncyc = ncyc;
            last_len  = run_len;
         end
         if (frame_done === 1'b1) done_cnt++;
         flag_prev = lvds_flag;
      end
   end

   initial begin
      repeat (60000) @(negedge clk);
      $display("FAIL watchdog: bench did not finish within the cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, st2, st3, r0, d0, n, k;

      rst = 1'b1;
      tick(3);
      check("rst_flag", {31'b0, lvds_flag}, 0);
      check("rst_d0", {31'b0, lvds_data0}, 0);
      check("rst_d1", {31'b0, lvds_data1}, 0);
      check("rst_done", {31'b0, frame_done}, 0);
      check("rst_underrun", {31'b0, underrun}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_ready", {31'b0, strm.s_ready}, 1);
      rst = 1'b0;

      // Single frame, continuous data.
      queue_frame(FL, 0, 0);
      tick(3);
      pulse_start(st);
      wait_done("t1_done", 1, FLAG_CYC + 50);
      check("t1_latency", rise_ncyc - st, 1);
      check("t1_len", last_len, FLAG_CYC);
      check("t1_first_l0", {28'b0, first0}, 32'h1);
      check("t1_first_l1", {28'b0, first1}, 32'h0);
      check("t1_underrun", {31'b0, underrun}, 0);
      check("t1_exp_empty", exp_q.size(), 0);
      tick(MG + 2);
      check("t1_done_once", done_cnt, 1);
      check("t1_idle_busy", {31'b0, busy}, 0);

      // Back-to-back frames; third start arrives while one is pending.
      queue_frame(FL, 0, 3);
      queue_frame(FL, 0, 5);
      tick(3);
      pulse_start(st);
      tick(3);
      pulse_start(st2);
      check("t2_start_sep", st2 - st, 5);
      tick(100);
      pulse_start(st3);
      wait_done("t2_done", 3, 2 * FLAG_CYC + 200);
      check("t2_gap", last_gap, MG + 1);
      check("t2_len", last_len, FLAG_CYC);
      r0 = rises;
      tick(3 * MG);
      check("t2_no_third", rises, r0);
      check("t2_busy", {31'b0, busy}, 0);
      check("t2_done_total", done_cnt, 3);
      check("t2_exp_empty", exp_q.size(), 0);

      // Underrun after 10 bytes.
      queue_frame(10, FL - 10, 7);
      tick(3);
      pulse_start(st);
      wait_done("t3_done", 4, FLAG_CYC + 50);
      check("t3_underrun", {31'b0, underrun}, 1);
      check("t3_len", last_len, FLAG_CYC);
      check("t3_exp_empty", exp_q.size(), 0);
      tick(MG + 2);

      // Start with no data held.
      r0 = rises;
      pulse_start(st);
      tick(30);
      check("t4_no_flag", rises, r0);
      check("t4_flag_low", {31'b0, lvds_flag}, 0);
      check("t4_busy", {31'b0, busy}, 1);
      check("t4_underrun_sticky", {31'b0, underrun}, 1);
      n = ncyc;
      queue_frame(FL, 0, 9);
      k = 0;
      while (rises == r0 && k < 20) begin
         tick(1);
         k++;
      end
      check("t4_rise", rise_ncyc - n, 3);
      check("t4_underrun_clr", {31'b0, underrun}, 0);
      wait_done("t4_done", 5, FLAG_CYC + 50);
      check("t4_len", last_len, FLAG_CYC);
      check("t4_underrun_end", {31'b0, underrun}, 0);
      tick(MG + 2);

      // Reset in the middle of a frame, then a fresh full frame.
      queue_frame(FL, 0, 11);
      tick(3);
      r0 = rises;
      pulse_start(st);
      k = 0;
      while ((rises == r0 || fbytes < 100) && k < 1000) begin
         tick(1);
         k++;
      end
      check("t5_reached", fbytes, 100);
      d0  = done_cnt;
      rst = 1'b1;
      feed.delete();
      exp_q.delete();
      tick(1);
      check("t5_flag", {31'b0, lvds_flag}, 0);
      check("t5_d0", {31'b0, lvds_data0}, 0);
      check("t5_d1", {31'b0, lvds_data1}, 0);
      check("t5_ready", {31'b0, strm.s_ready}, 1);
      check("t5_busy", {31'b0, busy}, 0);
      check("t5_done_pulse", {31'b0, frame_done}, 0);
      rst = 1'b0;
      tick(5);
      check("t5_no_done", done_cnt, d0);
      queue_frame(FL, 0, 13);
      tick(3);
      pulse_start(st);
      wait_done("t5_fresh_done", d0 + 1, FLAG_CYC + 50);
      check("t5_fresh_len", last_len, FLAG_CYC);
      check("t5_fresh_exp_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
